// File: rtl/rs_hs_pipeline_rr_scheduler.sv
// Credit-gated round-robin scheduler: merges NUM_REQ FWFT producers onto one
// handshake channel, tagging each word with its source index.
module rs_hs_pipeline_rr_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TAG_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned CREDITS    = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_empty_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_dout,
  output logic [NUM_REQ-1:0]              req_read,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] out_din,
  output logic                            out_write,
  input  logic                            out_full_n,
  input  logic                            credit_return,
  output logic [7:0]                      credit_cnt,
  output logic                            credit_err
);

  localparam int unsigned BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [7:0]  CREDIT_MAX = 8'(CREDITS);

  logic                  out_vld_r;
  logic                  prev_load;
  logic [TAG_WIDTH-1:0]  rr_ptr;
  logic [TAG_WIDTH-1:0]  last_grant;
  logic [BURST_W-1:0]    burst_cnt;

  logic                  fire;
  logic                  load;
  logic                  stick;
  logic                  found;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [TAG_WIDTH-1:0]  next_ptr;
  logic [TAG_WIDTH-1:0]  scan_tag;
  logic [BURST_W-1:0]    burst_nxt;
  logic [DATA_WIDTH-1:0] grant_data;
  int unsigned           scan_idx;

  // Held words leave only when the head accepts and a far-end slot is reserved.
  assign fire      = out_vld_r & out_full_n & (credit_cnt != 8'd0) & ~reset;
  assign out_write = fire;
  assign load      = (~out_vld_r | fire) & (|req_empty_n) & ~reset;

  // Stick with the previous winner only across back-to-back loads.
  always_comb begin
    stick     = prev_load && (32'(burst_cnt) < MAX_BURST - 1) && req_empty_n[last_grant];
    grant_idx = last_grant;
    burst_nxt = burst_cnt + BURST_W'(1);
    found     = 1'b0;
    scan_idx  = 0;
    scan_tag  = '0;
    if (!stick) begin
      grant_idx = '0;
      burst_nxt = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = 32'(rr_ptr) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        scan_tag = TAG_WIDTH'(scan_idx);
        if (!found && req_empty_n[scan_tag]) begin
          found     = 1'b1;
          grant_idx = scan_tag;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (TAG_WIDTH'(i) == grant_idx) grant_data = req_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
    next_ptr = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + TAG_WIDTH'(1);
    req_read = load ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_r  <= 1'b0;
      out_din    <= '0;
      prev_load  <= 1'b0;
      rr_ptr     <= '0;
      last_grant <= '0;
      burst_cnt  <= '0;
      credit_cnt <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      prev_load <= load;
      if (load) begin
        out_din    <= {grant_idx, grant_data};
        out_vld_r  <= 1'b1;
        last_grant <= grant_idx;
        rr_ptr     <= next_ptr;
        burst_cnt  <= burst_nxt;
      end else begin
        if (fire) out_vld_r <= 1'b0;
        burst_cnt <= '0;
      end
      // A return against a full counter indicates a protocol error downstream.
      if (fire && !credit_return) begin
        credit_cnt <= credit_cnt - 8'd1;
      end else if (credit_return && !fire) begin
        if (credit_cnt == CREDIT_MAX) credit_err <= 1'b1;
        else                          credit_cnt <= credit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/rs_hs_pipeline_rr_scheduler.md
Name: rs_hs_pipeline_rr_scheduler

Overview:
- Round-robin scheduler that shares one handshake pipeline channel (FIFO-style write side: if_full_n/if_write/if_din) among NUM_REQ first-word-fall-through producers.
- Tags each word with its source index and holds it in a one-word output register.
- Gates issue on a credit counter sized to the far-end buffer depth, so the pipelined channel can never overflow regardless of ready latency.
- Sits between producer FIFOs and the head of a relay-station pipeline; credit returns come from the tail consumer.

Parameters:
- DATA_WIDTH, 32, payload width per requester.
- NUM_REQ, 4, number of requesters (2..16).
- TAG_WIDTH, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), source-index tag width.
- CREDITS, 8, initial and maximum credit count (1..255); equals far-end buffer depth.
- MAX_BURST, 4, maximum consecutive grants to one requester before forced rotation (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_empty_n  in  NUM_REQ  bit i high: requester i has a word at req_dout.
- req_dout  in  NUM_REQ*DATA_WIDTH  flat payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_read  out  NUM_REQ  one-hot pop strobe to requester FIFOs.
- out_din  out  DATA_WIDTH+TAG_WIDTH  {tag, payload} to pipeline head.
- out_write  out  1  write strobe to pipeline head.
- out_full_n  in  1  pipeline head can accept.
- credit_return  in  1  one pulse = one downstream slot freed.
- credit_cnt  out  8  current credits.
- credit_err  out  1  sticky: credit_return received while credit_cnt==CREDITS.

Behaviour:
- Reset (synchronous, sampled on the clk edge while reset=1) clears all state:
  - out_vld_r=0, out_din=0, out_write=0, req_read=0.
  - rr_ptr=0, last_grant=0, burst_cnt=0.
  - credit_cnt=CREDITS, credit_err=0.
  - Reset mid-operation discards the held word; producers are not re-read.
- Output stage:
  - out_write = out_vld_r & out_full_n & (credit_cnt!=0), combinational from registers and out_full_n.
  - fire = out_write.
  - A word stays in the register, stable, until fire.
- Load condition: load = (!out_vld_r | fire) & (|req_empty_n).
  - On load: out_din <= {grant_idx, req_dout[grant_idx]}, out_vld_r <= 1, req_read[grant_idx]=1 in the same cycle (combinational).
  - Otherwise req_read = 0.
  - If fire with no load: out_vld_r <= 0.
- Latency: word popped in cycle t is presented in cycle t+1. With continuous credits, throughput is 1 word/cycle.
- Grant selection (priority order):
  1. Stick: if burst_cnt < MAX_BURST-1 and req_empty_n[last_grant], grant last_grant; burst_cnt++.
  2. Otherwise grant the first i with req_empty_n[i] scanning from rr_ptr upward, wrapping modulo NUM_REQ; burst_cnt <= 0 (the first grant of a burst counts as 0).
- After any load: last_grant <= grant_idx, rr_ptr <= (grant_idx+1) mod NUM_REQ.
- Stickiness applies only across back-to-back loads. Any idle cycle (no load) resets burst_cnt to 0, so the next grant scans from rr_ptr.
- MAX_BURST=1: pure round-robin.
- Credits:
  - fire & !credit_return: credit_cnt--.
  - credit_return & !fire: credit_cnt++, saturating at CREDITS. If already CREDITS, no change and credit_err <= 1.
  - Both in the same cycle: unchanged.
  - credit_cnt==0 blocks fire even when out_full_n=1. Loading still stalls because out_vld_r=1.
- Boundaries:
  - All req_empty_n low: no load, req_read=0.
  - out_full_n low: word held, no pop, no credit change.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - credit_err clears only on reset.

Test Plan:
- NUM_REQ=4, MAX_BURST=1, all four requesters continuously non-empty, out_full_n=1, credit_return pulsed every fire -> tags 0,1,2,3,0,1… one per cycle; first out_write one cycle after the first req_read.
- MAX_BURST=4, only req 2 and req 3 non-empty -> tags 2,2,2,2,3,3,3,3,2…; with req 2 alone -> burst of 4, then req 2 regranted (it is the only candidate), with no idle cycle.
- CREDITS=8, never return credits, all requesters busy -> exactly 8 fires, then out_write=0 with out_vld_r held and credit_cnt=0. One credit_return pulse -> exactly one more fire.
- out_full_n low for 5 cycles while holding payload 0xDEADBEEF tag 1 -> out_din stable, req_read=0 throughout; the word is written on the first cycle out_full_n=1.
- Simultaneous fire and credit_return at credit_cnt=3 -> stays 3. credit_return at credit_cnt=8 -> stays 8, credit_err=1 and sticky.
- reset asserted while a word is held at credit_cnt=2 -> next cycle out_write=0, credit_cnt=8, rr_ptr=0; the first post-reset grant goes to the lowest-index non-empty requester.
